// File: rtl/fibo_pkg.sv
// Shared constants and state encoding for the Fibonacci sweep requester.
package fibo_pkg;

  localparam int FIBO_SIZE    = 4;
  localparam int FIBO_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ISSUE,
    WAIT,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/fibo_result_buf.sv
// Result store: 2^SIZE entries, one synchronous write port, combinational read.
module fibo_result_buf #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [SIZE-1:0] wr_addr,
  input  logic [SIZE-1:0] wr_data,
  input  logic [SIZE-1:0] rd_addr,
  output logic [SIZE-1:0] rd_data
);

  localparam int DEPTH = 1 << SIZE;

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fibo_requester.sv
// Sweeps a Fibonacci calculator over FIRST..LAST and stores each result in order.
//   state  | meaning
//   IDLE   | waiting for GO
//   DRAIN  | waiting for a stale DONE to drop before issuing
//   ISSUE  | one-cycle START with COUNT=idx
//   WAIT   | waiting for DONE, capture DATA
//   NEXT   | stop at last_r or advance idx
//   FINISH | end of sweep, SWEEP_DONE follows
module fibo_requester
  import fibo_pkg::*;
#(
  parameter int SIZE    = FIBO_SIZE,
  parameter int TIMEOUT = FIBO_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            GO,
  input  logic [SIZE-1:0] FIRST,
  input  logic [SIZE-1:0] LAST,
  output logic            START,
  output logic [SIZE-1:0] COUNT,
  input  logic            DONE,
  input  logic [SIZE-1:0] DATA,
  input  logic [SIZE-1:0] RD_ADDR,
  output logic [SIZE-1:0] RD_DATA,
  output logic            BUSY,
  output logic            SWEEP_DONE,
  output logic            ERR,
  output logic [SIZE:0]   NUM_RESULTS
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_t state, state_next;

  logic [SIZE-1:0] idx;
  logic [SIZE-1:0] last_r;
  logic [TW-1:0]   tmr;
  logic            tmr_hit;
  logic            go_accept;
  logic            capture;
  logic            expire;

  assign tmr_hit = (tmr == TMR_LAST);

  // DONE takes priority over the timeout so a last-cycle result is kept.
  always_comb begin
    state_next = state;
    go_accept  = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    START      = 1'b0;
    BUSY       = 1'b1;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (GO) begin
          go_accept  = 1'b1;
          state_next = (FIRST > LAST) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        if (!DONE) begin
          state_next = ISSUE;
        end else if (tmr_hit) begin
          expire     = 1'b1;
          state_next = FINISH;
        end
      end
      ISSUE: begin
        START      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (DONE) begin
          capture    = 1'b1;
          state_next = NEXT;
        end else if (tmr_hit) begin
          expire     = 1'b1;
          state_next = FINISH;
        end
      end
      NEXT:    state_next = (idx == last_r) ? FINISH : DRAIN;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx         <= '0;
      last_r      <= '0;
      COUNT       <= '0;
      tmr         <= '0;
      NUM_RESULTS <= '0;
      ERR         <= 1'b0;
      SWEEP_DONE  <= 1'b0;
    end else begin
      SWEEP_DONE <= (state == FINISH);
      if (go_accept) begin
        idx         <= FIRST;
        last_r      <= LAST;
        NUM_RESULTS <= '0;
        ERR         <= 1'b0;
      end
      if (state == NEXT && state_next == DRAIN) idx <= idx + 1'b1;
      if (state_next == ISSUE) COUNT <= idx;
      if (capture) NUM_RESULTS <= NUM_RESULTS + 1'b1;
      if (expire) ERR <= 1'b1;
      // Restart the wait budget on every state change; count only while waiting.
      if (state_next != state) tmr <= '0;
      else if (state == DRAIN || state == WAIT) tmr <= tmr + 1'b1;
    end
  end

  fibo_result_buf #(
    .SIZE(SIZE)
  ) u_buf (
    .clk     (CLK),
    .rst     (RST),
    .we      (capture),
    .wr_addr (NUM_RESULTS[SIZE-1:0]),
    .wr_data (DATA),
    .rd_addr (RD_ADDR),
    .rd_data (RD_DATA)
  );

endmodule

// File: tb/tb_fibo_requester.sv
// Directed bench for fibo_requester with a simple calculator model (results mod 16).
module tb_fibo_requester;

  localparam int SIZE    = 4;
  localparam int TIMEOUT = 64;

  logic            CLK = 1'b0;
  logic            RST;
  logic            GO;
  logic [SIZE-1:0] FIRST, LAST, COUNT, DATA, RD_ADDR, RD_DATA;
  logic            START, DONE, BUSY, SWEEP_DONE, ERR;
  logic [SIZE:0]   NUM_RESULTS;

  int checks   = 0;
  int failures = 0;

  int lat = 1, hold = 1, skip_idx = -1;
  logic force_done = 1'b0;
  logic [SIZE-1:0] stale_data = 4'hE;
  logic done_m = 1'b0;
  logic [SIZE-1:0] data_m = '0;
  logic pending = 1'b0;
  int lat_cnt = 0, hold_cnt = 0, req_idx = 0;

  int cyc = 0, sd_cnt = 0, start4_cyc = -1, err_cyc = -1;
  logic arm_c = 1'b0;
  int starts[$];

  int exp_sweep[8] = '{0, 1, 1, 2, 3, 5, 8, 13};

  assign DONE = done_m | force_done;
  assign DATA = force_done ? stale_data : data_m;

  always #5 CLK = ~CLK;

  fibo_requester #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .GO(GO), .FIRST(FIRST), .LAST(LAST),
    .START(START), .COUNT(COUNT), .DONE(DONE), .DATA(DATA),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BUSY(BUSY),
    .SWEEP_DONE(SWEEP_DONE), .ERR(ERR), .NUM_RESULTS(NUM_RESULTS)
  );

  function automatic logic [SIZE-1:0] fib(input int n);
    logic [SIZE-1:0] a, b, t;
    a = '0;
    b = 4'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Calculator: answers lat cycles after START, holds DONE for hold cycles.
  always @(negedge CLK) begin
    if (RST) begin
      done_m  = 1'b0;
      data_m  = '0;
      pending = 1'b0;
    end else if (START) begin
      pending = 1'b1;
      req_idx = int'(COUNT);
      lat_cnt = lat;
      done_m  = 1'b0;
    end else if (pending) begin
      if (lat_cnt > 1) lat_cnt--;
      else if (req_idx != skip_idx) begin
        pending  = 1'b0;
        done_m   = 1'b1;
        data_m   = fib(req_idx);
        hold_cnt = hold;
      end
    end else if (done_m) begin
      if (hold_cnt > 1) hold_cnt--;
      else done_m = 1'b0;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (START) begin
      starts.push_back(int'(COUNT));
      if (arm_c && COUNT == 4'd4 && start4_cyc < 0) start4_cyc = cyc;
    end
    if (SWEEP_DONE === 1'b1) sd_cnt++;
    if (arm_c && ERR === 1'b1 && err_cyc < 0) err_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_go(input logic [SIZE-1:0] f, input logic [SIZE-1:0] l);
    FIRST = f;
    LAST  = l;
    GO    = 1'b1;
    @(negedge CLK);
    GO    = 1'b0;
  endtask

  task automatic wait_sd(input string tag, input int budget);
    int n = 0;
    while (SWEEP_DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(SWEEP_DONE), 32'd1);
  endtask

  task automatic check_buf(input string tag, input int addr, input int exp);
    RD_ADDR = addr[SIZE-1:0];
    @(negedge CLK);
    check(tag, 32'(RD_DATA), 32'(exp));
  endtask

  task automatic check_starts(input string tag, input int base, input int first, input int n);
    check({tag, "_n"}, 32'(starts.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_idx"}, 32'((base + i < starts.size()) ? starts[base + i] : -1), 32'(first + i));
  endtask

  int base, sd0, n;

  initial begin
    RST = 1'b1; GO = 1'b0; FIRST = '0; LAST = '0; RD_ADDR = '0;
    tick(2);
    check("rst_start", 32'(START), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_sweep_done", 32'(SWEEP_DONE), 0);
    check("rst_err", 32'(ERR), 0);
    check("rst_count", 32'(COUNT), 0);
    check("rst_num", 32'(NUM_RESULTS), 0);
    check_buf("rst_buf9", 9, 0);
    RST = 1'b0;
    tick(2);

    // Full sweep 0..7; a second GO mid-sweep must be ignored.
    lat = 2; hold = 3;
    base = starts.size(); sd0 = sd_cnt;
    pulse_go(4'd0, 4'd7);
    tick(3);
    check("a_busy", 32'(BUSY), 1);
    pulse_go(4'd9, 4'd9);
    wait_sd("a_sweep_done", 600);
    tick(3);
    check("a_sd_pulses", 32'(sd_cnt - sd0), 1);
    check_starts("a_starts", base, 0, 8);
    check("a_num", 32'(NUM_RESULTS), 8);
    check("a_err", 32'(ERR), 0);
    check("a_busy_end", 32'(BUSY), 0);
    check("a_count_hold", 32'(COUNT), 7);
    for (int i = 0; i < 8; i++) check_buf("a_buf", i, exp_sweep[i]);

    // Empty range: straight to FINISH, SWEEP_DONE two cycles after GO.
    base = starts.size();
    FIRST = 4'd5; LAST = 4'd3; GO = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
    check("b_sd_early", 32'(SWEEP_DONE), 0);
    check("b_busy", 32'(BUSY), 1);
    @(negedge CLK);
    check("b_sd", 32'(SWEEP_DONE), 1);
    check("b_num", 32'(NUM_RESULTS), 0);
    tick(1);
    check("b_no_start", 32'(starts.size() - base), 0);
    check("b_count_hold", 32'(COUNT), 7);
    check_buf("b_keep5", 5, 5);
    check_buf("b_keep7", 7, 13);

    // Calculator never answers index 4 of a 2..6 sweep.
    lat = 1; hold = 1; skip_idx = 4;
    arm_c = 1'b1;
    base = starts.size();
    pulse_go(4'd2, 4'd6);
    wait_sd("c_sweep_done", 300);
    tick(2);
    check("c_err", 32'(ERR), 1);
    check("c_num", 32'(NUM_RESULTS), 2);
    check("c_err_latency", 32'(err_cyc - (start4_cyc + 1)), 32'(TIMEOUT));
    check_starts("c_starts", base, 2, 3);
    check_buf("c_buf0", 0, 1);
    check_buf("c_buf1", 1, 2);
    check_buf("c_keep4", 4, 3);
    check("c_err_sticky", 32'(ERR), 1);
    arm_c = 1'b0;

    // DONE already high at GO: START withheld until it drops.
    force_done = 1'b1; hold = 2;
    base = starts.size();
    pulse_go(4'd6, 4'd6);
    check("d_err_clr", 32'(ERR), 0);
    tick(8);
    check("d_busy", 32'(BUSY), 1);
    check("d_withheld", 32'(starts.size() - base), 0);
    force_done = 1'b0;
    wait_sd("d_sweep_done", 100);
    tick(1);
    check_starts("d_starts", base, 6, 1);
    check("d_num", 32'(NUM_RESULTS), 1);
    check_buf("d_buf0", 0, 8);

    // Top of the index range must not wrap.
    base = starts.size();
    pulse_go(4'd14, 4'd15);
    wait_sd("e_sweep_done", 100);
    tick(5);
    check_starts("e_starts", base, 14, 2);
    check("e_num", 32'(NUM_RESULTS), 2);
    check("e_count", 32'(COUNT), 15);
    check("e_busy", 32'(BUSY), 0);
    check_buf("e_buf0", 0, 9);
    check_buf("e_buf1", 1, 2);

    // Reset during WAIT aborts, then a fresh sweep completes.
    skip_idx = -1; lat = 5; hold = 1;
    RD_ADDR = '0;
    sd0 = sd_cnt;
    base = starts.size();
    pulse_go(4'd0, 4'd7);
    n = 0;
    while (starts.size() < base + 4 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("f_reach_idx3", 32'(starts.size() >= base + 4), 1);
    tick(2);
    RST = 1'b1;
    #1;
    check("f_rst_start", 32'(START), 0);
    check("f_rst_busy", 32'(BUSY), 0);
    check("f_rst_sd", 32'(SWEEP_DONE), 0);
    check("f_rst_err", 32'(ERR), 0);
    check("f_rst_count", 32'(COUNT), 0);
    check("f_rst_num", 32'(NUM_RESULTS), 0);
    check("f_rst_buf0", 32'(RD_DATA), 0);
    tick(3);
    RST = 1'b0;
    tick(2);
    check("f_no_sd", 32'(sd_cnt - sd0), 0);
    lat = 1; hold = 2;
    base = starts.size();
    pulse_go(4'd0, 4'd7);
    wait_sd("f_sweep_done", 600);
    tick(3);
    check("f_sd_pulses", 32'(sd_cnt - sd0), 1);
    check_starts("f_starts", base, 0, 8);
    check("f_num", 32'(NUM_RESULTS), 8);
    check("f_err", 32'(ERR), 0);
    for (int i = 0; i < 8; i++) check_buf("f_buf", i, exp_sweep[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
